// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32I core constants: datapath width, register
//               address width, named architectural register indices and the
//               stack/global pointer reset values. The linker script uses the
//               same sp/gp values.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;

    localparam logic [XLEN-1:0] SP_RESET = 32'h0000_3FFC;
    localparam logic [XLEN-1:0] GP_RESET = 32'h0000_1800;

endpackage : core_pkg
`default_nettype wire

// File: rtl/reg_file_rdport.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rdport
// Description : One combinational read port of the register file. It selects
//               the addressed word, forces x0 to read as zero and, when
//               REG_FILE_BYPASS_EN is defined, forwards the write-port data to
//               the read port if it targets the same register in this cycle.
// Ports       : rst_n  - active-low reset; forwarding is suppressed while low
//               ra     - read address
//               regs   - flattened storage contents
//               we/wa/wd - write port of the current cycle (forwarding source)
//               rd     - read data
// Config      : REG_FILE_BYPASS_EN - enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rdport
    import core_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic                            rst_n,
    input  logic [REG_ADDR_W-1:0]           ra,
    input  logic [NREGS_P-1:0][XLEN_P-1:0]  regs,
    input  logic                            we,
    input  logic [REG_ADDR_W-1:0]           wa,
    input  logic [XLEN_P-1:0]               wd,
    output logic [XLEN_P-1:0]               rd
);

    logic [XLEN_P-1:0] w_stored;

    assign w_stored = regs[ra];

`ifdef REG_FILE_BYPASS_EN
    logic w_fwd;

    // Forward only a real, committed write: x0 writes are dropped and reset
    // discards the write, so neither may be forwarded.
    assign w_fwd = rst_n && we && (wa != '0) && (wa == ra);

    always_comb begin
        rd = w_stored;
        if (ra == '0) begin
            rd = '0;
        end else if (w_fwd) begin
            rd = wd;
        end
    end
`else
    // Forwarding inputs exist only so both builds share one port list.
    logic w_unused;
    assign w_unused = ^{rst_n, we, wa, wd};

    always_comb begin
        rd = w_stored;
        if (ra == '0) begin
            rd = '0;
        end
    end
`endif

endmodule : reg_file_rdport
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : RV32I architectural register file, 32 x 32-bit. x0 reads as
//               zero. Two combinational read ports, one write port that
//               commits on the rising clock edge, and a committed-write
//               counter for performance/debug.
// Ports       : clk        - core clock
//               rst_n      - synchronous active-low reset
//               ra1/rd1    - read port 1 (rs1 -> ALU operand a)
//               ra2/rd2    - read port 2 (rs2 -> ALU operand b / store data)
//               we3/wa3/wd3- write port (rd, write-back value)
//               wr_cnt     - count of committed writes, wraps modulo 2^32
// Config      : REG_FILE_BYPASS_EN - write-to-read forwarding on both ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import core_pkg::*;
#(
    parameter int                 XLEN_P     = XLEN,
    parameter int                 NREGS_P    = NREGS,
    parameter logic [XLEN_P-1:0]  SP_RESET_P = SP_RESET,
    parameter logic [XLEN_P-1:0]  GP_RESET_P = GP_RESET
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  ra1,
    input  logic [REG_ADDR_W-1:0]  ra2,
    output logic [XLEN_P-1:0]      rd1,
    output logic [XLEN_P-1:0]      rd2,
    input  logic                   we3,
    input  logic [REG_ADDR_W-1:0]  wa3,
    input  logic [XLEN_P-1:0]      wd3,
    output logic [31:0]            wr_cnt
);

    logic [NREGS_P-1:0][XLEN_P-1:0] r_regs;
    logic [31:0]                    r_wr_cnt;
    logic                           w_commit;

    assign w_commit = we3 && (wa3 != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS_P; i++) begin
                if (i == REG_SP) begin
                    r_regs[i] <= SP_RESET_P;
                end else if (i == REG_GP) begin
                    r_regs[i] <= GP_RESET_P;
                end else begin
                    r_regs[i] <= '0;
                end
            end
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_regs[wa3] <= wd3;
            r_wr_cnt    <= r_wr_cnt + 32'd1;
        end
    end

    assign wr_cnt = r_wr_cnt;

    reg_file_rdport #(
        .XLEN_P  (XLEN_P),
        .NREGS_P (NREGS_P)
    ) u_rdport1 (
        .rst_n (rst_n),
        .ra    (ra1),
        .regs  (r_regs),
        .we    (we3),
        .wa    (wa3),
        .wd    (wd3),
        .rd    (rd1)
    );

    reg_file_rdport #(
        .XLEN_P  (XLEN_P),
        .NREGS_P (NREGS_P)
    ) u_rdport2 (
        .rst_n (rst_n),
        .ra    (ra2),
        .regs  (r_regs),
        .we    (we3),
        .wa    (wa3),
        .wd    (wd3),
        .rd    (rd2)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Directed vectors with
//               hand-computed expectations, followed by a randomised run
//               against a reference array model. Inputs change on the falling
//               edge; outputs are sampled 1 ns later, well before the next
//               rising edge.
// Config      : REG_FILE_BYPASS_EN selects the forwarding expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] rd1, rd2, wd3, wr_cnt;
    logic        we3;

    int n_cmp;
    int n_err;

`ifdef REG_FILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    reg_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .we3    (we3),
        .wa3    (wa3),
        .wd3    (wd3),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model for the random phase
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] reset_val(input int i);
        if (i == 2) return 32'h0000_3FFC;
        if (i == 3) return 32'h0000_1800;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (c_BYPASS && rst_n && we3 && (wa3 != 5'd0) && (wa3 == ra)) return wd3;
        return m_regs[ra];
    endfunction

    // Apply one cycle's inputs on the falling edge, then settle.
    task automatic drive(input logic rn, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst_n = rn; we3 = w; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;

        // ---------------- Reset: two cycles low, then read everything
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("rst_wr_cnt", wr_cnt, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            check($sformatf("rst_rd1_x%0d", i), rd1, reset_val(i));
            check($sformatf("rst_rd2_x%0d", 31 - i), rd2, reset_val(31 - i));
        end

        // ---------------- Basic write / read
        drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd6, 32'h1234_5678, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        check("wr_rd1_x5", rd1, 32'hDEAD_BEEF);
        check("wr_rd2_x6", rd2, 32'h1234_5678);
        check("wr_cnt_2", wr_cnt, 32'd2);

        // ---------------- x0 immutability
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("x0_rd1_same_cycle", rd1, 32'h0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h0);
        check("x0_cnt", wr_cnt, 32'd2);

        // ---------------- Read-during-write
        drive(1'b1, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd5);
        check("rdw_before_edge", rd1, c_BYPASS ? 32'h2 : 32'h1);
        check("rdw_other_port", rd2, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        check("rdw_after_rd1", rd1, 32'h2);
        check("rdw_after_rd2", rd2, 32'h2);
        check("rdw_cnt", wr_cnt, 32'd4);

        // ---------------- Reset collision
        drive(1'b0, 1'b1, 5'd2, 32'hAAAA_AAAA, 5'd5, 5'd2);
        check("rstlow_old_x5", rd1, 32'hDEAD_BEEF);
        check("rstlow_no_fwd_x2", rd2, 32'h0000_3FFC);
        check("rstlow_old_cnt", wr_cnt, 32'd4);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        check("coll_x2", rd1, 32'h0000_3FFC);
        check("coll_x5", rd2, 32'h0);
        check("coll_cnt", wr_cnt, 32'h0);

        // ---------------- Counter wrap
        @(negedge clk);
        force dut.r_wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_cnt;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h0BAD_F00D; ra1 = 5'd9; ra2 = 5'd0;
        #1;
        check("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        check("wrap_cnt", wr_cnt, 32'h0);
        check("wrap_x9", rd1, 32'h0BAD_F00D);

        // ---------------- Random regression against the model
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        for (int i = 0; i < 32; i++) m_regs[i] = reset_val(i);
        m_cnt = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 99) != 0), 1'($urandom), 5'($urandom),
                  $urandom, 5'($urandom), 5'($urandom));
            check("rnd_rd1", rd1, model_rd(ra1));
            check("rnd_rd2", rd2, model_rd(ra2));
            check("rnd_cnt", wr_cnt, m_cnt);
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) m_regs[i] = reset_val(i);
                m_cnt = 32'h0;
            end else if (we3 && wa3 != 5'd0) begin
                m_regs[wa3] = wd3;
                m_cnt = m_cnt + 32'd1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural integer register file for the single-cycle RV32I core.
- Sits directly upstream of the ALU: read port 1 drives ALU operand a; read port 2 drives operand b, or the immediate mux ahead of b.
- The write port takes the write-back value: the ALU result, load data or PC+4, selected outside this block.
- 32 x 32-bit. x0 is hardwired to zero. Reads are combinational, writes occur at the clock edge.

Parameters:
- XLEN, 32, register width.
- NREGS, 32, number of architectural registers (power of two).
- SP_RESET, 32'h0000_3FFC, reset value of x2 (sp).
- GP_RESET, 32'h0000_1800, reset value of x3 (gp).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ra1  input  5  read address, port 1 (rs1).
- ra2  input  5  read address, port 2 (rs2).
- rd1  output  XLEN  read data, port 1 (to ALU a).
- rd2  output  XLEN  read data, port 2 (to ALU b / store data).
- we3  input  1  write enable.
- wa3  input  5  write address (rd).
- wd3  input  XLEN  write data.
- wr_cnt  output  32  count of committed writes (performance/debug).

Behaviour:
- Reset: on a rising clk edge with rst_n=0:
  - all registers clear to 0, except x2=SP_RESET and x3=GP_RESET;
  - wr_cnt clears to 0;
  - any write presented in the same cycle is discarded (reset wins).
- Write: on a rising edge with rst_n=1, we3=1 and wa3!=0:
  - reg[wa3] <= wd3 and wr_cnt increments by 1;
  - wr_cnt wraps from 32'hFFFF_FFFF to 0 with no saturation.
- Writes with wa3=0 are silently dropped and do not increment wr_cnt.
- we3=0: no state change; wa3 and wd3 are don't-care.
- Read: rd1 and rd2 are purely combinational from ra1/ra2 and current register state, so zero-cycle latency.
  - ra=0 always returns 0, even if a write to 0 was attempted.
  - Both ports may address the same register and return identical data.
- Read-during-write, same cycle, same address, without the bypass feature: the read returns the OLD value; the new value is visible the cycle after the edge.
- Reads while rst_n=0 return current (pre-reset) contents until the reset edge, then reset values.
- Reset reasserted mid-program: takes effect at the next edge regardless of we3.
- Output after reset: rd1/rd2 reflect reset contents of the addressed registers (0, SP_RESET or GP_RESET).
- No X propagation: every stored register has a defined reset value.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If we3=1, wa3!=0, rst_n=1 and ra1==wa3, then rd1=wd3 combinationally; same rule for ra2/rd2.
  - Used when the core is later pipelined with write-back and decode in the same cycle.
  - ra=0 still returns 0.
  - No forwarding while rst_n=0.
- Not defined: no forwarding; read-during-write returns the old value as above.
- Storage, reset and wr_cnt behaviour are identical in both builds.

Decomposition:
- Shared package core_pkg holds:
  - XLEN;
  - REG_ADDR_W=5;
  - named register indices (REG_ZERO=0, REG_RA=1, REG_SP=2, REG_GP=3);
  - the SP_RESET/GP_RESET defaults, which the linker script mirrors.
- Sub-module: one natural sub-module, reg_file_rdport (address decode + x0 mask + optional bypass mux), instantiated twice.
- The storage array and wr_cnt stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release, read all 32 addresses -> x2=32'h0000_3FFC, x3=32'h0000_1800, all others 0, wr_cnt=0.
- Basic write/read:
  - write x5=32'hDEAD_BEEF, then x6=32'h1234_5678;
  - next cycle ra1=5, ra2=6 -> rd1=DEADBEEF, rd2=12345678, wr_cnt=2.
- x0 immutability: we3=1, wa3=0, wd3=32'hFFFF_FFFF; then ra1=ra2=0 -> rd1=rd2=0, wr_cnt unchanged.
- Read-during-write:
  - x7=32'h1 stored; in one cycle write x7=32'h2 with ra1=7;
  - before the edge: rd1=1 without REG_FILE_BYPASS_EN, rd1=2 with it;
  - after the edge: rd1=2 in both builds.
- Reset collision: we3=1, wa3=2, wd3=32'hAAAA_AAAA with rst_n=0 at the same edge -> x2=32'h0000_3FFC, wr_cnt=0.
- Counter wrap (force wr_cnt=32'hFFFF_FFFF) and random regression:
  - a valid write -> wr_cnt=0;
  - 10k random we3/wa3/wd3/ra1/ra2 cycles checked against a reference array model with no mismatches.
